// File: rtl/stopwatch_lap_timer_pkg.sv
// Shared types and constants for the stopwatch / lap timer.
// Time fields are plain binary counters, not BCD.
package stopwatch_lap_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } sw_state_e;

  localparam int SUBSEC_W = 7;
  localparam int SEC_W    = 6;

  localparam logic [SUBSEC_W-1:0] SUBSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]    SEC_MAX    = 6'd59;

endpackage

// File: rtl/stopwatch_lap_timer_lap_fifo.sv
// Lap capture FIFO: drops pushes while full (no bypass on same-cycle pop),
// flush empties it in one cycle.
module sw_lap_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign valid   = (wr_q != rd_q);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && valid && !flush;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/stopwatch_lap_timer.sv
// min:sec:centisec stopwatch / countdown timer with tick divider,
// start/stop/clear/load control and a lap-capture FIFO.
module stopwatch_lap_timer
  import stopwatch_lap_timer_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int MIN_MAX   = 59,
  parameter int MIN_W     = 6,
  parameter int LAP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                mode_down,
  input  logic                load,
  input  logic [MIN_W-1:0]    load_min,
  input  logic [SEC_W-1:0]    load_sec,
  input  logic [SUBSEC_W-1:0] load_subsec,
  input  logic                lap,
  output logic [MIN_W-1:0]    min,
  output logic [SEC_W-1:0]    sec,
  output logic [SUBSEC_W-1:0] subsec,
  output logic                running,
  output logic                expired,
  output logic                wrapped,
  output logic                lap_valid,
  input  logic                lap_ready,
  output logic [MIN_W-1:0]    lap_min,
  output logic [SEC_W-1:0]    lap_sec,
  output logic [SUBSEC_W-1:0] lap_subsec,
  output logic                lap_overflow
);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int LAP_W = MIN_W + SEC_W + SUBSEC_W;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [MIN_W-1:0] MIN_TOP  = MIN_W'(MIN_MAX);

  sw_state_e           state_q, state_d;
  logic                down_q, down_d;
  logic [MIN_W-1:0]    min_q, min_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [SUBSEC_W-1:0] sub_q, sub_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                wrap_q, wrap_d;
  logic                ovf_q, ovf_d;

  logic idle_or_pause, is_zero, at_one, tick;
  logic do_load, do_run, do_start;
  logic lap_push, fifo_full, fifo_valid;
  logic [LAP_W-1:0] fifo_dout;

  assign idle_or_pause = (state_q == ST_IDLE) || (state_q == ST_PAUSE);
  assign is_zero  = (min_q == '0) && (sec_q == '0) && (sub_q == '0);
  assign at_one   = (min_q == '0) && (sec_q == '0) &&
                    (sub_q == SUBSEC_W'(1));
  assign tick     = (state_q == ST_RUN) && (div_q == DIV_LAST);
  assign do_load  = !clear && load && idle_or_pause;
  assign do_run   = !clear && (state_q == ST_RUN);
  assign do_start = !clear && !load && start && idle_or_pause &&
                    !(down_q && is_zero);
  assign lap_push = lap && !clear &&
                    ((state_q == ST_RUN) || (state_q == ST_PAUSE));

  always_comb begin
    state_d = state_q;
    down_d  = down_q;
    min_d   = min_q;
    sec_d   = sec_q;
    sub_d   = sub_q;
    div_d   = div_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q || (lap_push && fifo_full);
    unique case (1'b1)
      clear: begin
        state_d = ST_IDLE;
        down_d  = mode_down;
        min_d   = '0;
        sec_d   = '0;
        sub_d   = '0;
        div_d   = '0;
        ovf_d   = 1'b0;
      end
      do_load: begin
        down_d = mode_down;
        min_d  = (load_min > MIN_TOP) ? MIN_TOP : load_min;
        sec_d  = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;
        sub_d  = (load_subsec > SUBSEC_MAX) ? SUBSEC_MAX : load_subsec;
        div_d  = '0;
      end
      do_run: begin
        if (stop) state_d = ST_PAUSE;
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick && down_q) begin
          // Expiry beats a same-cycle stop.
          if (at_one) state_d = ST_EXPIRED;
          if (sub_q != '0) begin
            sub_d = sub_q - SUBSEC_W'(1);
          end else begin
            sub_d = SUBSEC_MAX;
            if (sec_q != '0) begin
              sec_d = sec_q - SEC_W'(1);
            end else begin
              sec_d = SEC_MAX;
              min_d = min_q - MIN_W'(1);
            end
          end
        end else if (tick) begin
          if (sub_q != SUBSEC_MAX) begin
            sub_d = sub_q + SUBSEC_W'(1);
          end else begin
            sub_d = '0;
            if (sec_q != SEC_MAX) begin
              sec_d = sec_q + SEC_W'(1);
            end else begin
              sec_d = '0;
              if (min_q != MIN_TOP) begin
                min_d = min_q + MIN_W'(1);
              end else begin
                min_d  = '0;
                wrap_d = 1'b1;
              end
            end
          end
        end
      end
      do_start: state_d = ST_RUN;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      down_q  <= 1'b0;
      min_q   <= '0;
      sec_q   <= '0;
      sub_q   <= '0;
      div_q   <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      down_q  <= down_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      sub_q   <= sub_d;
      div_q   <= div_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  sw_lap_fifo #(
    .WIDTH(LAP_W),
    .DEPTH(LAP_DEPTH)
  ) u_lap_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (clear),
    .push   (lap_push),
    .din    ({min_q, sec_q, sub_q}),
    .full   (fifo_full),
    .pop    (lap_ready),
    .valid  (fifo_valid),
    .dout   (fifo_dout)
  );

  assign min          = min_q;
  assign sec          = sec_q;
  assign subsec       = sub_q;
  assign running      = (state_q == ST_RUN);
  assign expired      = (state_q == ST_EXPIRED);
  assign wrapped      = wrap_q;
  assign lap_overflow = ovf_q;
  assign lap_valid    = fifo_valid;
  assign {lap_min, lap_sec, lap_subsec} = fifo_valid ? fifo_dout : '0;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Bench for stopwatch_lap_timer: directed table, corner sequences and
// a randomized run against a total-centisecond reference model.
module tb_stopwatch_lap_timer;
  localparam int TD = 4;
  localparam int MM = 2;
  localparam int MW = 2;
  localparam int LD = 4;
  localparam int TMAX = (MM + 1) * 6000;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 0, stop = 0, clear = 0, mode_down = 0;
  logic          load = 0, lap = 0, lap_ready = 0;
  logic [MW-1:0] load_min = '0;
  logic [5:0]    load_sec = '0;
  logic [6:0]    load_subsec = '0;
  logic [MW-1:0] min, lap_min;
  logic [5:0]    sec, lap_sec;
  logic [6:0]    subsec, lap_subsec;
  logic          running, expired, wrapped, lap_valid, lap_overflow;

  always #5 clk = ~clk;

  stopwatch_lap_timer #(
    .TICK_DIV(TD), .MIN_MAX(MM), .MIN_W(MW), .LAP_DEPTH(LD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .clear(clear), .mode_down(mode_down), .load(load),
    .load_min(load_min), .load_sec(load_sec),
    .load_subsec(load_subsec), .lap(lap), .min(min), .sec(sec),
    .subsec(subsec), .running(running), .expired(expired),
    .wrapped(wrapped), .lap_valid(lap_valid), .lap_ready(lap_ready),
    .lap_min(lap_min), .lap_sec(lap_sec), .lap_subsec(lap_subsec),
    .lap_overflow(lap_overflow)
  );

  int m_st, m_t, m_ph;
  bit m_down, m_wrap, m_ovf;
  int m_q[$];
  int n_chk = 0, n_fail = 0;

  function automatic logic [31:0] enc(logic [MW-1:0] m, logic [5:0] s,
                                      logic [6:0] c);
    return 32'(m) * 100000 + 32'(s) * 1000 + 32'(c);
  endfunction

  function automatic int enc_t(int t);
    return (t / 6000) * 100000 + ((t / 100) % 60) * 1000 + t % 100;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = S_IDLE; m_t = 0; m_ph = 0;
    m_down = 0; m_wrap = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic m_step();
    bit ip   = (m_st == S_IDLE) || (m_st == S_PAUSE);
    bit full = (m_q.size() == LD);
    bit push = lap && !clear && (m_st == S_RUN || m_st == S_PAUSE);
    bit pop  = (m_q.size() != 0) && lap_ready && !clear;
    int pre  = m_t;
    int lm, ls, lc;
    m_wrap = 0;
    if (clear) begin
      m_st = S_IDLE; m_t = 0; m_ph = 0; m_ovf = 0;
      m_down = mode_down;
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (full) m_ovf = 1;
        else m_q.push_back(pre);
      end
      if (load && ip) begin
        lm = (int'(load_min) > MM) ? MM : int'(load_min);
        ls = (int'(load_sec) > 59) ? 59 : int'(load_sec);
        lc = (int'(load_subsec) > 99) ? 99 : int'(load_subsec);
        m_t = lm * 6000 + ls * 100 + lc;
        m_down = mode_down;
        m_ph = 0;
      end else if (m_st == S_RUN) begin
        if (stop) m_st = S_PAUSE;
        if (m_ph == TD - 1) begin
          m_ph = 0;
          if (m_down) begin
            m_t--;
            if (m_t == 0) m_st = S_EXP;
          end else if (m_t == TMAX - 1) begin
            m_t = 0;
            m_wrap = 1;
          end else begin
            m_t++;
          end
        end else begin
          m_ph++;
        end
      end else if (start && ip && !(m_down && m_t == 0)) begin
        m_st = S_RUN;
      end
    end
  endtask

  task automatic check_all(string tag);
    logic [31:0] hexp;
    chk({tag, " time"}, enc(min, sec, subsec), 32'(enc_t(m_t)));
    chk({tag, " flags"},
        {27'd0, running, expired, wrapped, lap_valid, lap_overflow},
        {27'd0, m_st == S_RUN, m_st == S_EXP, m_wrap,
         m_q.size() != 0, m_ovf});
    hexp = (m_q.size() != 0) ? 32'(enc_t(m_q[0])) : 32'd0;
    chk({tag, " lap"}, enc(lap_min, lap_sec, lap_subsec), hexp);
  endtask

  task automatic step(string tag = "step");
    m_step();
    @(posedge clk);
    #1;
    check_all(tag);
    start = 0; stop = 0; clear = 0; load = 0; lap = 0;
  endtask

  task automatic do_clear(bit dn);
    clear = 1; mode_down = dn;
    step("clear");
  endtask

  task automatic do_load(bit dn, int lm, int ls, int lc);
    load = 1; mode_down = dn;
    load_min = MW'(lm); load_sec = 6'(ls); load_subsec = 7'(lc);
    step("load");
  endtask

  typedef struct {
    bit st, sp, cl, ld, dn;
    int lm, ls, lc;
    int n;
    int em, es, ec;
    bit er, ex, ew;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int cnt, nwrap, r;

    tbl[0]  = '{0,0,0,1,1, 0,0,3,   1, 0,0,3,   0,0,0};
    tbl[1]  = '{1,0,0,0,0, 0,0,0,   1, 0,0,3,   1,0,0};
    tbl[2]  = '{0,0,0,0,0, 0,0,0,   4, 0,0,2,   1,0,0};
    tbl[3]  = '{0,0,0,0,0, 0,0,0,   4, 0,0,1,   1,0,0};
    tbl[4]  = '{0,0,0,0,0, 0,0,0,   4, 0,0,0,   0,1,0};
    tbl[5]  = '{1,0,0,0,0, 0,0,0,   1, 0,0,0,   0,1,0};
    tbl[6]  = '{0,0,0,1,1, 0,0,50,  1, 0,0,0,   0,1,0};
    tbl[7]  = '{0,0,1,0,0, 0,0,0,   1, 0,0,0,   0,0,0};
    tbl[8]  = '{1,0,0,0,0, 0,0,0,   1, 0,0,0,   1,0,0};
    tbl[9]  = '{0,0,0,0,0, 0,0,0,   4, 0,0,1,   1,0,0};
    tbl[10] = '{0,1,0,0,0, 0,0,0,   1, 0,0,1,   0,0,0};
    tbl[11] = '{0,0,0,1,0, 1,30,20, 1, 1,30,20, 0,0,0};
    tbl[12] = '{0,0,0,1,0, 3,63,120,1, 2,59,99, 0,0,0};
    tbl[13] = '{1,0,0,0,0, 0,0,0,   1, 2,59,99, 1,0,0};
    tbl[14] = '{0,0,0,0,0, 0,0,0,   4, 0,0,0,   1,0,1};
    tbl[15] = '{0,0,0,0,0, 0,0,0,   1, 0,0,0,   1,0,0};

    m_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    chk("reset time", enc(min, sec, subsec), 0);
    reset_n = 1;
    @(negedge clk);

    // 1: async reset while running at 0:01.37
    do_load(0, 0, 1, 37);
    start = 1; step("t1 start");
    step(); step();
    chk("t1 pre time", enc(min, sec, subsec), 1037);
    @(negedge clk);
    reset_n = 0;
    #1;
    m_reset();
    check_all("t1 reset");
    chk("t1 reset out", {enc(min, sec, subsec)[15:0], 11'd0,
        running, expired, wrapped, lap_valid, lap_overflow}, 0);
    @(negedge clk);
    reset_n = 1;
    step("t1 after");

    // table: down-count/expiry, clamp, pause load and up wrap
    do_clear(0);
    foreach (tbl[i]) begin
      start = tbl[i].st; stop = tbl[i].sp; clear = tbl[i].cl;
      load = tbl[i].ld; mode_down = tbl[i].dn;
      load_min = MW'(tbl[i].lm); load_sec = 6'(tbl[i].ls);
      load_subsec = 7'(tbl[i].lc);
      step("tbl");
      for (int k = 1; k < tbl[i].n; k++) step("tbl");
      chk($sformatf("tbl%0d time", i), enc(min, sec, subsec),
          32'(tbl[i].em * 100000 + tbl[i].es * 1000 + tbl[i].ec));
      chk($sformatf("tbl%0d flags", i), {29'd0, running, expired, wrapped},
          {29'd0, tbl[i].er, tbl[i].ex, tbl[i].ew});
    end

    // 2: full up run from zero, one wrap
    do_clear(0);
    start = 1; step("t2 start");
    nwrap = 0;
    for (int k = 0; k < TMAX * TD; k++) begin
      step("t2");
      if (wrapped === 1'b1) nwrap++;
    end
    chk("t2 wraps", nwrap, 1);
    chk("t2 wrap edge", {31'd0, wrapped}, 1);
    step("t2");
    chk("t2 continue", {31'd0, running}, 1);

    // 4: pause keeps divider phase
    do_clear(0);
    start = 1; step("t4 start");
    for (int k = 0; k < 9; k++) step("t4");
    stop = 1; step("t4 stop");
    chk("t4 stop time", enc(min, sec, subsec), 2);
    for (int k = 0; k < 5; k++) step("t4 pause");
    chk("t4 pause time", enc(min, sec, subsec), 2);
    start = 1; step("t4 resume");
    step("t4");
    chk("t4 no tick yet", enc(min, sec, subsec), 2);
    step("t4");
    chk("t4 tick", enc(min, sec, subsec), 3);

    // 5: five laps into a four-deep FIFO, then drain in order
    do_clear(0);
    lap_ready = 0;
    start = 1; step("t5 start");
    for (int k = 0; k < 17; k++) begin
      lap = (k % 4 == 0);
      step("t5");
    end
    chk("t5 held", {30'd0, lap_valid, lap_overflow}, 3);
    lap_ready = 1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (lap_valid !== 1'b1) break;
      chk("t5 order", enc(lap_min, lap_sec, lap_subsec), 32'(cnt));
      cnt++;
      step("t5 drain");
    end
    chk("t5 count", cnt, 4);
    lap_ready = 0;

    // 6: clear wins over stop/start/load from PAUSE
    lap = 1; step("t6 lap");
    stop = 1; step("t6 stop");
    chk("t6 pre", {29'd0, running, lap_valid, lap_overflow}, 3);
    clear = 1; stop = 1; start = 1; load = 1; mode_down = 0;
    load_min = 1; load_sec = 0; load_subsec = 0;
    step("t6 combo");
    chk("t6 time", enc(min, sec, subsec), 0);
    chk("t6 flags", {27'd0, running, expired, wrapped, lap_valid,
        lap_overflow}, 0);

    // randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      r = $urandom_range(0, 15);
      start = (r <= 1);
      stop = (r == 2);
      clear = (r == 3) && ($urandom_range(0, 3) == 0);
      load = (r == 4);
      mode_down = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        load_min = '0; load_sec = '0;
        load_subsec = 7'($urandom_range(0, 12));
      end else begin
        load_min = MW'($urandom); load_sec = 6'($urandom);
        load_subsec = 7'($urandom);
      end
      lap = ($urandom_range(0, 3) == 0);
      lap_ready = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
